// File: rtl/icache_axi_refill_if.sv
// AXI4 read-address and read-data channels between the icache refill stage and memory.
// master = refill stage (issues AR, accepts R); slave = memory / interconnect side.
interface icache_axi_refill_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/icache_axi_refill.sv
// Memory-side icache stage: line refills as one INCR burst, uncached fetches as single beats.
// Latency: line return 10 cycles after request, uncached 3; each arready/rvalid stall adds one.
// Backpressure: one outstanding AXI read; new requests wait in IDLE until the return pulse.
module icache_axi_refill #(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd_req,
  input  logic [31:0]             rd_addr,
  output logic                    ret_valid,
  output logic [32*LINE_WORDS-1:0] ret_data,
  input  logic                    iucache_ren_i,
  input  logic [31:0]             iucache_addr_i,
  output logic                    iucache_rvalid_o,
  output logic [31:0]             iucache_rdata_o,
  icache_axi_refill_if.master     axi
);

  localparam int         BW       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int         OFF_BITS = $clog2(4 * LINE_WORDS);
  localparam logic [BW-1:0] BEAT_MAX = BW'(LINE_WORDS - 1);
  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_RET
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        kind_line;
  logic [BW-1:0] beat;
  logic [31:0] words [LINE_WORDS];
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [31:0] unc_rdata_q;
  logic        arvalid_c;
  logic        rready_c;
  logic        beat_fire;

  // ID and response are not needed with a single transaction in flight.
  logic unused_rsp;
  assign unused_rsp = ^{axi.rid, axi.rresp};

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_c;
  assign axi.rready  = rready_c;

  assign iucache_rdata_o = unc_rdata_q;
  assign beat_fire       = rready_c && axi.rvalid;

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_line
      assign ret_data[32*gi +: 32] = words[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    arvalid_c        = 1'b0;
    rready_c         = 1'b0;
    ret_valid        = 1'b0;
    iucache_rvalid_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_req || iucache_ren_i) begin
          state_nxt = S_AR;
        end
      end
      S_AR: begin
        arvalid_c = 1'b1;
        if (axi.arready) begin
          state_nxt = S_R;
        end
      end
      S_R: begin
        rready_c = 1'b1;
        if (axi.rvalid && axi.rlast) begin
          state_nxt = S_RET;
        end
      end
      S_RET: begin
        ret_valid        = kind_line;
        iucache_rvalid_o = !kind_line;
        state_nxt        = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      araddr_q    <= '0;
      arlen_q     <= '0;
      kind_line   <= 1'b0;
      beat        <= '0;
      unc_rdata_q <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        words[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          // Line refill wins when both requesters ask in the same cycle.
          if (rd_req) begin
            araddr_q  <= {rd_addr[31:OFF_BITS], {OFF_BITS{1'b0}}};
            arlen_q   <= LINE_LEN;
            kind_line <= 1'b1;
          end else if (iucache_ren_i) begin
            araddr_q  <= iucache_addr_i;
            arlen_q   <= 8'd0;
            kind_line <= 1'b0;
          end
        end
        S_AR: begin
          if (axi.arready) begin
            beat <= '0;
          end
        end
        S_R: begin
          if (beat_fire) begin
            if (kind_line) begin
              // Counter sticks at the last word so overlong bursts keep rewriting it.
              words[beat] <= axi.rdata;
              if (beat != BEAT_MAX) begin
                beat <= beat + 1'b1;
              end
            end else begin
              unc_rdata_q <= axi.rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
